uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UARTTx transmitter between NUM_REQ byte requesters (echo path, status reporter, debug dumper, ...).
Accepts one byte per grant and drives the transmitter's active-low tx_en start strobe and tx_byte. It then waits for tx_complete, or aborts on timeout, before granting the next requester.
Sits between the top-level control logic and uart_tx, replacing ad-hoc tx_en sequencing in the top-level FSM.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 48000, max cycles to wait in each wait state before abort (1 ms at 48 MHz)
GRANT_W, $clog2(NUM_REQ), width of grant_id (derived, not overridden)

Ports:
sourceClk  in  1  system clock (48 MHz)
reset  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester byte-valid; held until matching req_ready pulse
req_data  in  8*NUM_REQ  flattened bytes; requester i on bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse
tx_en  out  1  to UARTTx; 0 = start transmission, 1 = idle/disabled
tx_byte  out  8  byte to UARTTx; stable from START until next grant
tx_complete  in  1  from UARTTx; high when transmitter idle/finished
busy  out  1  high in every state except IDLE
grant_id  out  GRANT_W  index of current/last granted requester
timeout_err  out  1  one-cycle pulse on transmit abort

Behaviour:
- Reset values: state=IDLE, tx_en=1, tx_byte=0, req_ready=0, busy=0, grant_id=0, timeout_err=0, last_grant=NUM_REQ-1 (requester 0 wins first arbitration), timeout counter=0.
- Reset asserted in any state returns everything to reset values at the next edge. No partial handshake survives. In-flight UARTTx frame is not this block's concern.
- All outputs are registered.
- States: IDLE, START, WAIT_CLR, WAIT_DONE, DONE.
- IDLE:
  - If any req_valid bit is set at edge k, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register grant_id=g, last_grant=g, tx_byte=req_data[g], req_ready=onehot(g), tx_en=0, busy=1. Go to START.
  - No valid: stay, outputs unchanged.
- START (one cycle; req_ready and tx_en=0 visible):
  - Next edge: req_ready=0, tx_en=1, counter=0 -> WAIT_CLR.
- WAIT_CLR:
  - Waits for tx_complete==0, proving the transmitter accepted the start.
  - tx_complete==0 -> WAIT_DONE, counter=0.
  - This guards against a stale high tx_complete from the previous frame.
- WAIT_DONE: tx_complete==1 -> DONE.
- Timeout: in WAIT_CLR or WAIT_DONE, the counter increments each cycle. When counter == TIMEOUT_CYCLES-1 and the exit condition is not met:
  - timeout_err=1 for one cycle, go to DONE.
  - Exit condition true on the same cycle wins over timeout (no error).
- DONE (one cycle): busy=0 on exit, timeout_err cleared -> IDLE. Guarantees at least one idle cycle between bytes.
- Requester contract:
  - Keep req_valid/req_data stable until req_ready seen.
  - Deassert req_valid, or present the next byte, by the edge ending the req_ready cycle.
  - Arbiter samples req_valid only in IDLE.
- Fairness: a continuously requesting requester is granted at most once per NUM_REQ grants while others request. Timeouts still advance last_grant.
- Minimum per-byte latency from req_valid to next IDLE: 1 (IDLE) + 1 (START) + ≥1 (WAIT_CLR) + ≥1 (WAIT_DONE) + 1 (DONE).

Test Plan:
- Single request: req_valid=0001, data0=0x41; UARTTx model drops tx_complete 2 cycles after tx_en=0, raises it 4170 cycles later -> req_ready=0001 for exactly 1 cycle; tx_en=0 for exactly 1 cycle; tx_byte=0x41; grant_id=0; no timeout_err; busy returns 0.
- Simultaneous requests: req_valid=1011 held, data 0x10/0x11/0x13 (requesters 0/1/3) -> transmit order 0x10, 0x11, 0x13, then 0x10 again; each req_ready one-hot pulse once per grant.
- Stale tx_complete: tx_complete held high for 5 cycles after tx_en=0, then low, then high -> arbiter stays in WAIT_CLR those 5 cycles; exactly one byte completes; no early DONE.
- Timeout: tx_complete stuck at 1, TIMEOUT_CYCLES=16 -> timeout_err single pulse 16 cycles after WAIT_CLR entry; busy drops; next pending requester granted afterwards.
- Reset mid-WAIT_DONE: assert reset for 1 cycle -> tx_en=1, req_ready=0, busy=0, grant_id=0 next cycle; subsequent request from requester 2 is served normally.
- Wrap-around: last_grant=3, req_valid=0101 -> requester 0 granted before requester 2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter/sequencer sharing one UART transmitter between
// NUM_REQ byte requesters. One byte is accepted per grant. The block pulses
// the active-low tx_en start strobe and holds tx_byte. It then waits for the
// transmitter to drop tx_complete (start accepted) and raise it again (frame
// done) before the next grant. A per-wait-state cycle budget aborts a hung
// transfer.
//
// Ports:
//   sourceClk    in   system clock (48 MHz)
//   reset        in   synchronous reset, active-high
//   req_valid    in   [NUM_REQ]   per-requester byte valid, held until req_ready
//   req_data     in   [8*NUM_REQ] flattened bytes, requester i on [8i+7:8i]
//   req_ready    out  [NUM_REQ]   one-hot, one-cycle acceptance pulse
//   tx_en        out  start strobe to transmitter, 0 = start, 1 = idle
//   tx_byte      out  [8]  byte to transmitter, stable until next grant
//   tx_complete  in   transmitter idle/finished flag
//   busy         out  high in every state except IDLE
//   grant_id     out  [GRANT_W] current/last granted requester
//   timeout_err  out  one-cycle pulse when a transfer is aborted
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 48000,
    parameter int GRANT_W        = $clog2(NUM_REQ)
) (
    input  logic                   sourceClk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_en,
    output logic [7:0]             tx_byte,
    input  logic                   tx_complete,
    output logic                   busy,
    output logic [GRANT_W-1:0]     grant_id,
    output logic                   timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t             state_r;
    logic [GRANT_W-1:0] last_grant_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               pick_found_s;
    logic [GRANT_W-1:0] pick_idx_s;
    logic [7:0]         pick_byte_s;
    logic               timeout_hit_s;

    // Round-robin pick: first valid requester after last_grant_r, with wrap.
    always_comb begin
        logic [GRANT_W-1:0] cand_v;
        pick_found_s = 1'b0;
        pick_idx_s   = {GRANT_W{1'b0}};
        pick_byte_s  = 8'h00;
        cand_v       = {GRANT_W{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_v = GRANT_W'((int'(last_grant_r) + i) % NUM_REQ);
            if (!pick_found_s && req_valid[cand_v]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_v;
                pick_byte_s  = req_data[{cand_v, 3'b000} +: 8];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Last allowed wait cycle; the exit condition on this cycle still wins.
    always_comb begin
        if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge sourceClk) begin
        if (reset) begin
            state_r      <= IDLE;
            tx_en        <= 1'b1;
            tx_byte      <= 8'h00;
            req_ready    <= {NUM_REQ{1'b0}};
            busy         <= 1'b0;
            grant_id     <= {GRANT_W{1'b0}};
            timeout_err  <= 1'b0;
            last_grant_r <= GRANT_W'(NUM_REQ - 1);
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        grant_id     <= pick_idx_s;
                        last_grant_r <= pick_idx_s;
                        tx_byte      <= pick_byte_s;
                        req_ready    <= NUM_REQ'(1'b1) << pick_idx_s;
                        tx_en        <= 1'b0;
                        busy         <= 1'b1;
                        state_r      <= START;
                    end
                end
                START: begin
                    req_ready <= {NUM_REQ{1'b0}};
                    tx_en     <= 1'b1;
                    cnt_r     <= {CNT_W{1'b0}};
                    state_r   <= WAIT_CLR;
                end
                // tx_complete must fall first, so a stale high level left
                // over from the previous frame is not mistaken for completion.
                WAIT_CLR: begin
                    if (!tx_complete) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= WAIT_DONE;
                    end else if (timeout_hit_s) begin
                        timeout_err <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_complete) begin
                        state_r <= DONE;
                    end else if (timeout_hit_s) begin
                        timeout_err <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                // One guaranteed idle cycle between bytes.
                DONE: begin
                    busy        <= 1'b0;
                    timeout_err <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    tx_en       <= 1'b1;
                    req_ready   <= {NUM_REQ{1'b0}};
                    busy        <= 1'b0;
                    timeout_err <= 1'b0;
                    cnt_r       <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic sourceClk = 1'b0;
    always #5 sourceClk = ~sourceClk;

    logic reset = 1'b1;

    // Main instance: long timeout so a 4170-cycle frame completes.
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_en;
    logic [7:0]        tx_byte;
    logic              tx_complete;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout_err;

    // Second instance: TIMEOUT_CYCLES=16 with tx_complete stuck high.
    logic [NREQ-1:0]   b_valid = '0;
    logic [8*NREQ-1:0] b_data  = '0;
    logic [NREQ-1:0]   b_ready;
    logic              b_tx_en;
    logic [7:0]        b_tx_byte;
    logic              b_busy;
    logic [1:0]        b_grant_id;
    logic              b_timeout_err;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(5000)) u_dut (
        .sourceClk(sourceClk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_en(tx_en), .tx_byte(tx_byte), .tx_complete(tx_complete),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(16)) u_dut_to (
        .sourceClk(sourceClk), .reset(reset),
        .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .tx_en(b_tx_en), .tx_byte(b_tx_byte), .tx_complete(1'b1),
        .busy(b_busy), .grant_id(b_grant_id), .timeout_err(b_timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model: tx_complete falls drop_dly cycles after tx_en=0 is
    // seen and rises again frame_len cycles later.
    int drop_dly  = 2;
    int frame_len = 6;
    initial begin
        tx_complete = 1'b1;
        forever begin
            @(negedge sourceClk);
            if (tx_en === 1'b0) begin
                repeat (drop_dly) @(negedge sourceClk);
                tx_complete = 1'b0;
                repeat (frame_len) @(negedge sourceClk);
                tx_complete = 1'b1;
            end
        end
    end

    // Scoreboard entry: granted requester, byte, busy-high cycles (0 = skip).
    typedef struct {
        int         gid;
        logic [7:0] data;
        int         blen;
    } exp_t;
    exp_t exp_q[$];

    exp_t mon_e;
    int   busy_cnt  = 0;
    int   blen_exp  = 0;
    bit   a_to_seen = 1'b0;

    // Monitor: any cycle with a ready pulse or a start strobe is a grant.
    always @(negedge sourceClk) begin
        if (req_ready !== 4'b0000 || tx_en !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(req_ready), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("grant_id", 32'(grant_id), 32'(mon_e.gid));
                chk("req_ready", 32'(req_ready), 32'(1) << mon_e.gid);
                chk("tx_en_low", 32'(tx_en), 32'h0);
                chk("tx_byte", 32'(tx_byte), 32'(mon_e.data));
                blen_exp = mon_e.blen;
            end
        end
        if (busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt != 0) begin
            if (blen_exp != 0) chk("busy_len", 32'(busy_cnt), 32'(blen_exp));
            busy_cnt = 0;
        end
        if (timeout_err === 1'b1) a_to_seen = 1'b1;
    end

    function automatic exp_t mk(input int g, input logic [7:0] d, input int l);
        exp_t e;
        e.gid = g; e.data = d; e.blen = l;
        return e;
    endfunction

    task automatic wait_grants(input int n, input int bound);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < bound) begin
            @(negedge sourceClk);
            cyc++;
            if (req_ready !== 4'b0000) seen++;
        end
        chk("grant_wait", 32'(seen), 32'(n));
    endtask

    task automatic wait_idle(input int bound);
        int cyc = 0;
        bit ok = 1'b0;
        while (!ok && cyc < bound) begin
            @(negedge sourceClk);
            cyc++;
            if (busy === 1'b0 && tx_complete === 1'b1) ok = 1'b1;
        end
        chk("idle_wait", 32'(ok), 32'h1);
    endtask

    task automatic do_reset(input int cyc);
        @(negedge sourceClk);
        reset = 1'b1;
        repeat (cyc) @(negedge sourceClk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        // Reset values on both instances.
        repeat (3) @(negedge sourceClk);
        reset = 1'b0;
        chk("rst_tx_en", 32'(tx_en), 32'h1);
        chk("rst_tx_byte", 32'(tx_byte), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_b_busy", 32'(b_busy), 32'h0);

        // Single request, 4170-cycle frame: busy = 2 + 4170 + 2 cycles.
        drop_dly = 2; frame_len = 4170;
        req_data[7:0] = 8'h41;
        exp_q.push_back(mk(0, 8'h41, 4174));
        req_valid = 4'b0001;
        wait_grants(1, 20);
        req_valid = 4'b0000;
        wait_idle(5000);
        chk("single_queue_empty", 32'(exp_q.size()), 32'h0);

        // Simultaneous requests 1011 from reset: order 0,1,3,0; busy 2+6+2.
        do_reset(2);
        drop_dly = 2; frame_len = 6;
        req_data = {8'h13, 8'h00, 8'h11, 8'h10};
        exp_q.push_back(mk(0, 8'h10, 10));
        exp_q.push_back(mk(1, 8'h11, 10));
        exp_q.push_back(mk(3, 8'h13, 10));
        exp_q.push_back(mk(0, 8'h10, 10));
        req_valid = 4'b1011;
        wait_grants(4, 200);
        req_valid = 4'b0000;
        wait_idle(100);
        chk("multi_queue_empty", 32'(exp_q.size()), 32'h0);

        // Stale tx_complete high for 5 cycles: busy 5+6+2; last_grant=0.
        drop_dly = 5; frame_len = 6;
        req_data[23:16] = 8'h5A;
        exp_q.push_back(mk(2, 8'h5A, 13));
        req_valid = 4'b0100;
        wait_grants(1, 20);
        req_valid = 4'b0000;
        wait_idle(100);
        chk("stale_queue_empty", 32'(exp_q.size()), 32'h0);

        // Reset in WAIT_DONE; busy length not checked for the aborted byte.
        drop_dly = 2; frame_len = 50;
        req_data[15:8] = 8'h22;
        exp_q.push_back(mk(1, 8'h22, 0));
        req_valid = 4'b0010;
        wait_grants(1, 20);
        req_valid = 4'b0000;
        repeat (10) @(negedge sourceClk);
        do_reset(1);
        chk("midrst_tx_en", 32'(tx_en), 32'h1);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_grant_id", 32'(grant_id), 32'h0);
        wait_idle(100);
        frame_len = 6;
        req_data[23:16] = 8'h37;
        exp_q.push_back(mk(2, 8'h37, 10));
        req_valid = 4'b0100;
        wait_grants(1, 20);
        req_valid = 4'b0000;
        wait_idle(100);

        // Wrap-around: serve 3 so last_grant=3, then 0101 -> 0 before 2.
        req_data[31:24] = 8'h63;
        exp_q.push_back(mk(3, 8'h63, 10));
        req_valid = 4'b1000;
        wait_grants(1, 20);
        req_valid = 4'b0000;
        wait_idle(100);
        req_data[7:0]   = 8'hA0;
        req_data[23:16] = 8'hA2;
        exp_q.push_back(mk(0, 8'hA0, 10));
        exp_q.push_back(mk(2, 8'hA2, 10));
        req_valid = 4'b0101;
        wait_grants(1, 20);
        req_valid = 4'b0100;
        wait_grants(1, 40);
        req_valid = 4'b0000;
        wait_idle(100);
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("no_timeout_main", 32'(a_to_seen), 32'h0);

        // Timeout instance: requesters 1 and 2, last_grant=3 -> 1 first.
        b_data = {8'h00, 8'hB2, 8'hB1, 8'h00};
        b_valid = 4'b0110;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge sourceClk); n++;
            if (b_ready !== 4'b0000) ok = 1'b1;
        end
        chk("to_grant1_wait", 32'(ok), 32'h1);
        chk("to_grant1_ready", 32'(b_ready), 32'h2);
        chk("to_grant1_id", 32'(b_grant_id), 32'h1);
        chk("to_grant1_byte", 32'(b_tx_byte), 32'hB1);
        b_valid = 4'b0100;
        // WAIT_CLR entered one cycle after the ready pulse, error 16 later.
        ok = 1'b0; n = 0;
        while (!ok && n < 100) begin
            @(negedge sourceClk); n++;
            if (b_timeout_err === 1'b1) ok = 1'b1;
        end
        chk("to_err_delay", 32'(n), 32'd17);
        @(negedge sourceClk);
        chk("to_err_pulse", 32'(b_timeout_err), 32'h0);
        chk("to_busy_drop", 32'(b_busy), 32'h0);
        @(negedge sourceClk);
        chk("to_grant2_ready", 32'(b_ready), 32'h4);
        chk("to_grant2_id", 32'(b_grant_id), 32'h2);
        chk("to_grant2_byte", 32'(b_tx_byte), 32'hB2);
        b_valid = 4'b0000;
        repeat (25) @(negedge sourceClk);
        chk("to_final_busy", 32'(b_busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
